// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter, 8N1, LSB first, idle-high line.
//
// A qualifying store is one with Write_Enable_i=1 and Device_i=UART_DEV. If Data_i[31]=0,
// Data_i[7:0] is queued. If the queue is full, the byte is dropped and the sticky Overflow
// bit is set. If Data_i[31]=1, Overflow is cleared and nothing is queued. The serialiser pops
// bytes back to back with no idle gap between frames. Each frame lasts 10*CLKS_PER_BIT cycles.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   Write_Enable_i store strobe
//   Device_i       device select from address decode
//   Data_i         store data
//   Tx_o           registered serial line
//   Status_o       {0..., count[2:0], Overflow, Full, Busy}
//   Full_o         copy of Status_o[1]
//
// Build option: define UART_TX_FIFO_EN for a 4-entry FIFO. When it is undefined, a single
// holding register is used instead.
module uart_tx_port #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [1:0]  UART_DEV     = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Write_Enable_i,
    input  logic [1:0]            Device_i,
    input  logic [DATA_WIDTH-1:0] Data_i,
    output logic                  Tx_o,
    output logic [DATA_WIDTH-1:0] Status_o,
    output logic                  Full_o
);
`ifdef UART_TX_FIFO_EN
    localparam int unsigned Depth = 4;
`else
    localparam int unsigned Depth = 1;
`endif
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    // Power-of-two sized so the pointer index always matches the array range.
    logic [7:0]        mem_q [2**PtrW];

    logic qual, push, pop, full, empty, baud_last;
    logic [DATA_WIDTH-1:0] data_unused;

    assign data_unused = Data_i;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    assign full      = (count_q == 3'(Depth));
    assign empty     = (count_q == 3'd0);
    assign qual      = Write_Enable_i && (Device_i == UART_DEV);
    // A pop in the same cycle does not free a slot for a push.
    assign push      = qual && !Data_i[31] && !full;
    assign baud_last = (baud_q == CntW'(CLKS_PER_BIT - 1));

    // Queue bookkeeping and sticky overflow.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (!push && pop) begin
            count_d = count_q - 3'd1;
        end
        ovf_d = ovf_q;
        if (qual && Data_i[31]) begin
            ovf_d = 1'b0;
        end else if (qual && full) begin
            ovf_d = 1'b1;
        end
    end

    // Serialiser next state and line value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Line value is derived from the next state so Tx_o changes on the same edge as the
        // state does.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= Data_i[7:0];
        end
    end

    always_comb begin
        Status_o      = '0;
        Status_o[0]   = (state_q != StIdle) || !empty;
        Status_o[1]   = full;
        Status_o[2]   = ovf_q;
        Status_o[5:3] = count_q;
    end

    assign Full_o = full;
    assign Tx_o   = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: scoreboard bench for uart_tx_port.
// Accepted bytes are queued when written. A line monitor decodes each frame, checks its
// framing, and compares the byte against the queue head.
`timescale 1ns/1ps
module tb_uart_tx_port;
    localparam int unsigned Clks        = 4;
    localparam int unsigned FrameCycles = 10 * Clks;
`ifdef UART_TX_FIFO_EN
    localparam int unsigned Depth    = 4;
    localparam logic [5:0]  BuildAcc = 6'b011111;  // bit i: i-th build write is accepted
    localparam int unsigned PairGap  = 1;
`else
    localparam int unsigned Depth    = 1;
    localparam logic [5:0]  BuildAcc = 6'b000101;
    localparam int unsigned PairGap  = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  dev;
    logic [31:0] data;
    logic        tx;
    logic [31:0] status;
    logic        full;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned wr_cyc;
    int unsigned n_starts = 0;
    logic [7:0]  sb_q[$];
    int unsigned starts_q[$];

    uart_tx_port #(
        .DATA_WIDTH  (32),
        .CLKS_PER_BIT(Clks),
        .UART_DEV    (2'b01)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Write_Enable_i(we),
        .Device_i      (dev),
        .Data_i        (data),
        .Tx_o          (tx),
        .Status_o      (status),
        .Full_o        (full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One store, accepted (or not) at the next rising edge; wr_cyc is that edge's number.
    task automatic wr(input logic en, input logic [1:0] d, input logic [31:0] v,
                      input logic acc);
        we   = en;
        dev  = d;
        data = v;
        @(posedge clk);
        #1;
        we     = 1'b0;
        wr_cyc = cyc;
        if (acc) sb_q.push_back(v[7:0]);
    endtask

    task automatic to_cyc(input int unsigned c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((sb_q.size() != 0 || status[0] !== 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    // Line monitor: sampled on falling edges, aborts a frame when reset is seen.
    initial begin : monitor
        logic [7:0] b;
        logic       ok;
        logic       abort;
        int         pos;
        int         sub;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                starts_q.push_back(cyc);
                n_starts++;
                ok    = 1'b1;
                abort = 1'b0;
                b     = 8'd0;
                for (int c = 0; c < int'(FrameCycles); c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        abort = 1'b1;
                        break;
                    end
                    pos = c / int'(Clks);
                    sub = c % int'(Clks);
                    if (pos == 0) begin
                        if (tx !== 1'b0) ok = 1'b0;
                    end else if (pos == 9) begin
                        if (tx !== 1'b1) ok = 1'b0;
                    end else if (sub == 0) begin
                        b[pos-1] = tx;
                    end else if (tx !== b[pos-1]) begin
                        ok = 1'b0;
                    end
                end
                if (!abort) begin
                    check("frame_fmt", {31'd0, ok}, 32'd1);
                    if (sb_q.size() == 0) check("frame_unexp", sb_q.size(), 1);
                    else check("frame_byte", {24'd0, b}, {24'd0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [7:0]  bytes [6];
        logic [31:0] exp_st;
        int unsigned n0;
        int unsigned k;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
        rst  = 1'b1;
        we   = 1'b0;
        dev  = 2'b00;
        data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_status", status, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        rst = 1'b0;

        // Single frame: latency and busy window.
        wr(1'b1, 2'b01, 32'h55, 1'b1);
        n0 = wr_cyc;
        @(negedge clk);
        check("lat_pre", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("lat_fall", {31'd0, tx}, 32'd0);
        to_cyc(n0 + FrameCycles);
        check("busy_end", {31'd0, status[0]}, 32'd1);
        @(negedge clk);
        check("busy_clr", {31'd0, status[0]}, 32'd0);
        drain("single_drain");

        // Two frames with no idle gap between them.
        starts_q.delete();
        wr(1'b1, 2'b01, 32'hA5, 1'b1);
        n0 = wr_cyc;
        if (PairGap > 1) begin
            @(posedge clk);
            #1;
        end
        wr(1'b1, 2'b01, 32'h3C, 1'b1);
        to_cyc(n0 + 2 * FrameCycles);
        check("pair_busy", {31'd0, status[0]}, 32'd1);
        @(negedge clk);
        check("pair_clr", {31'd0, status[0]}, 32'd0);
        check("pair_n", starts_q.size(), 2);
        check("pair_gap", (starts_q.size() == 2) ? starts_q[1] - starts_q[0] : 0, FrameCycles);
        drain("pair_drain");

        // Fill the queue, then overflow, clear, and ignored writes.
        for (int i = 0; i < 5; i++) wr(1'b1, 2'b01, {24'd0, bytes[i]}, BuildAcc[i]);
        check("build_full", {31'd0, full}, 32'd1);
        check("build_cnt", {29'd0, status[5:3]}, Depth);
        check("build_ovf", {31'd0, status[2]}, (Depth == 1) ? 32'd1 : 32'd0);
        wr(1'b1, 2'b01, {24'd0, bytes[5]}, BuildAcc[5]);
        check("ovf_set", {31'd0, status[2]}, 32'd1);
        wr(1'b1, 2'b01, 32'h8000_0000, 1'b0);
        check("ovf_clr", {31'd0, status[2]}, 32'd0);
        exp_st = {26'd0, 3'(Depth), 3'b011};
        check("st_after_clr", status, exp_st);
        wr(1'b1, 2'b10, 32'h12, 1'b0);
        check("dev_ignore", status, exp_st);
        wr(1'b0, 2'b01, 32'h34, 1'b0);
        check("we_ignore", status, exp_st);
        drain("build_drain");

        // Reset at cycle 15 of a frame with a second byte queued.
        wr(1'b1, 2'b01, 32'h96, 1'b1);
        n0 = wr_cyc;
        @(posedge clk);
        #1;
        wr(1'b1, 2'b01, 32'hC3, 1'b1);
        while (cyc < n0 + 15) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_status", status, 32'd0);
        check("abort_full", {31'd0, full}, 32'd0);
        rst = 1'b0;
        k = n_starts;
        repeat (60) @(negedge clk);
        check("abort_quiet", n_starts - k, 0);
        check("abort_idle", {31'd0, tx}, 32'd1);

        wr(1'b1, 2'b01, 32'h3A, 1'b1);
        drain("post_rst_drain");
        check("post_rst_frames", n_starts - k, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
